peri_charlieplex_pwm: RTL and testbench

//  Wishbone B4 peripheral driving an N-pin charlieplexed LED matrix.

---
 rtl/peri_charlieplex_pwm_if.sv | 11 +
 rtl/peri_charlieplex_pwm.sv | 109 ++++++++++
 tb/tb_peri_charlieplex_pwm.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/peri_charlieplex_pwm_if.sv
// peri_charlieplex_pwm_if: Wishbone B4 register bus bundle for the charlieplex PWM peripheral
interface peri_charlieplex_pwm_if;
  logic       wb_we_i;
  logic [3:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_stb_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  modport master (output wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i, input wb_dat_o, wb_ack_o);
  modport slave (input wb_we_i, wb_adr_i, wb_dat_i, wb_stb_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/peri_charlieplex_pwm.sv
// peri_charlieplex_pwm: Wishbone charlieplex LED scanner with PWM brightness, blanking step and readback
// Optional CHARLIEPLEX_DBUF_EN: double-buffered row registers swapped at frame end on commit.
module peri_charlieplex_pwm #(
  parameter int Pins       = 7,
  parameter int Rows       = 5,
  parameter int Cols       = 7,
  parameter int BrightBits = 4,
  parameter int PrescDiv   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  peri_charlieplex_pwm_if.slave  wb,
  output logic [Pins-1:0]        charlieplex_o,
  output logic [Pins-1:0]        charlieplex_oe,
  output logic                   frame_o
);
  localparam int PW = PrescDiv > 1 ? $clog2(PrescDiv) : 1;
  localparam int CW = Cols > 1 ? $clog2(Cols) : 1;
  localparam int RW = Rows > 1 ? $clog2(Rows) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PrescDiv - 1);
  localparam logic [CW-1:0] CMAX = CW'(Cols - 1);
  logic [PW-1:0]         r_presc;
  logic [BrightBits-1:0] r_step, r_bright;
  logic [CW-1:0]         r_col;
  logic [Cols-1:0]       r_row [Rows];
  logic [Cols-1:0]       w_scan [Rows];
  logic                  r_en, r_par, r_ack;
  logic [7:0]            r_dat, w_rdata;
  logic [Pins-1:0]       r_o, r_oe, w_o, w_oe;
  logic                  w_acc, w_wr, w_presc_wrap, w_step_wrap, w_frame, w_pend;
  assign w_acc        = wb.wb_stb_i & ~r_ack;
  assign w_wr         = w_acc & wb.wb_we_i;
  assign w_presc_wrap = r_presc == PMAX;
  assign w_step_wrap  = w_presc_wrap && r_step == '1;
  assign w_frame      = w_step_wrap && r_col == CMAX;
  assign wb.wb_ack_o    = r_ack;
  assign wb.wb_dat_o    = r_dat;
  assign charlieplex_o  = r_o;
  assign charlieplex_oe = r_oe;
  assign frame_o        = w_frame;
  assign w_rdata = (wb.wb_adr_i < 4'(Rows)) ? 8'(r_row[wb.wb_adr_i[RW-1:0]]) :
                   (wb.wb_adr_i == 4'h8)    ? {7'b0, r_en} :
                   (wb.wb_adr_i == 4'h9)    ? 8'(r_bright) :
                   (wb.wb_adr_i == 4'hA)    ? {6'b0, w_pend, r_par} : 8'h00;
  // Rows sit on pins 0..Pins-1 skipping the column pin, so row r shifts up once r reaches col.
  always_comb begin
    w_o  = '0;
    w_oe = '0;
    if (r_en && r_step != '0 && r_step <= r_bright) begin
      for (int r = 0; r < Rows; r++)
        if (w_scan[r][r_col]) begin
          if (r < int'(r_col)) begin
            w_o[r]  = 1'b1;
            w_oe[r] = 1'b1;
          end else begin
            w_o[r+1]  = 1'b1;
            w_oe[r+1] = 1'b1;
          end
        end
      if (|w_oe) w_oe[r_col] = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_presc  <= '0;
      r_step   <= '0;
      r_col    <= '0;
      r_en     <= 1'b0;
      r_par    <= 1'b0;
      r_ack    <= 1'b0;
      r_bright <= '1;
      r_dat    <= '0;
      r_o      <= '0;
      r_oe     <= '0;
      for (int r = 0; r < Rows; r++) r_row[r] <= '0;
    end else begin
      r_ack   <= w_acc;
      r_dat   <= w_acc ? w_rdata : 8'h00;
      r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
      r_o     <= w_o;
      r_oe    <= w_oe;
      if (w_presc_wrap) r_step <= r_step + 1'b1;
      if (w_step_wrap) r_col <= (r_col == CMAX) ? '0 : r_col + 1'b1;
      if (w_frame) r_par <= ~r_par;
      if (w_wr && wb.wb_adr_i < 4'(Rows)) r_row[wb.wb_adr_i[RW-1:0]] <= wb.wb_dat_i[Cols-1:0];
      if (w_wr && wb.wb_adr_i == 4'h8) r_en <= wb.wb_dat_i[0];
      if (w_wr && wb.wb_adr_i == 4'h9) r_bright <= wb.wb_dat_i[BrightBits-1:0];
    end
`ifdef CHARLIEPLEX_DBUF_EN
  logic            r_pend, w_commit;
  logic [Cols-1:0] r_front [Rows];
  assign w_commit = w_wr && wb.wb_adr_i == 4'h8 && wb.wb_dat_i[1];
  assign w_scan   = r_front;
  assign w_pend   = r_pend;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_pend <= 1'b0;
      for (int r = 0; r < Rows; r++) r_front[r] <= '0;
    end else if (w_frame && (r_pend || w_commit)) begin
      r_front <= r_row;
      r_pend  <= 1'b0;
    end else if (w_commit) begin
      r_pend <= 1'b1;
    end
`else
  assign w_scan = r_row;
  assign w_pend = 1'b0;
`endif
endmodule

// File: tb/tb_peri_charlieplex_pwm.sv
// tb_peri_charlieplex_pwm: randomized scoreboard bench for peri_charlieplex_pwm (Pins=7 Rows=5 Cols=7 BrightBits=2)
module tb_peri_charlieplex_pwm;
  localparam int FRAME = 28;
`ifdef CHARLIEPLEX_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif
  typedef struct {
    logic       we;
    logic [3:0] adr;
    logic [7:0] dat;
    logic [7:0] exp;
  } txn_t;

  logic clk = 1'b0, rst_ni = 1'b0;
  logic [6:0] o, oe;
  logic frame;
  int n_tests = 0, n_fail = 0, cyc = 0;
  txn_t q[$];

  always #5 clk = ~clk;

  peri_charlieplex_pwm_if wb();
  peri_charlieplex_pwm #(.Pins(7), .Rows(5), .Cols(7), .BrightBits(2), .PrescDiv(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wb(wb),
    .charlieplex_o(o), .charlieplex_oe(oe), .frame_o(frame));

  // cycles since reset release == the spec's free-running scan position
  always @(posedge clk or negedge rst_ni)
    if (!rst_ni) cyc <= 0;
    else cyc <= cyc + 1;

  // driver-side register shadow (what reads must return)
  logic [6:0] sh_row [5];
  logic       sh_en;
  logic [1:0] sh_bright;
  int         sh_commit;

  task automatic shadow_reset();
    for (int r = 0; r < 5; r++) sh_row[r] = '0;
    sh_en = 1'b0;
    sh_bright = 2'b11;
    sh_commit = -1;
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a, input int s);
    logic pend, par;
    pend = DBUF && sh_commit >= 0 && sh_commit < s && sh_commit / FRAME == s / FRAME;
    par = ((s / FRAME) % 2) == 1;
    if (a < 4'd5) return {1'b0, sh_row[a]};
    if (a == 4'h8) return {7'b0, sh_en};
    if (a == 4'h9) return {6'b0, sh_bright};
    if (a == 4'hA) return {6'b0, pend, par};
    return 8'h00;
  endfunction

  task automatic xfer(input logic we, input logic [3:0] adr, input logic [7:0] dat);
    txn_t t;
    int lat;
    @(posedge clk); #1;
    t.we = we; t.adr = adr; t.dat = dat; t.exp = exp_rd(adr, cyc);
    if (we) begin
      if (adr < 4'd5) sh_row[adr] = dat[6:0];
      if (adr == 4'h8) begin
        sh_en = dat[0];
        if (dat[1]) sh_commit = cyc;
      end
      if (adr == 4'h9) sh_bright = dat[1:0];
    end
    q.push_back(t);
    wb.wb_we_i = we; wb.wb_adr_i = adr; wb.wb_dat_i = dat; wb.wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wb.wb_ack_o && lat < 4);
    n_tests++;
    if (!wb.wb_ack_o || lat != 1) begin
      n_fail++;
      $display("FAIL ack_latency adr=%h: got %0d cycles (ack=%b), need 1", adr, lat, wb.wb_ack_o);
    end
    wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
  endtask

  task automatic run(input int k);
    repeat (k) @(posedge clk);
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    @(negedge clk);
    while (cyc % FRAME != ph && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL wait_phase: phase %0d not reached, at %0d", ph, cyc % FRAME);
    end
  endtask

  // monitor-side display model: rows as the bus left them, front buffer as the scan sees it
  logic [6:0] m_row [5], m_front [5], s_front [5];
  logic       m_en, s_en, m_pend, prev_ack;
  logic [1:0] m_bright, s_bright;

  function automatic logic [13:0] exp_pins(input int m);
    int step, col, p;
    logic [6:0] eo, eoe;
    step = m % 4;
    col = (m / 4) % 7;
    eo = '0; eoe = '0;
    if (s_en && step != 0 && step <= int'(s_bright)) begin
      for (int r = 0; r < 5; r++)
        if (s_front[r][col]) begin
          p = r < col ? r : r + 1;
          eo[p] = 1'b1;
          eoe[p] = 1'b1;
        end
      if (eoe != '0) eoe[col] = 1'b1;
    end
    return {eo, eoe};
  endfunction

  always @(negedge clk) begin
    txn_t t;
    logic [6:0] rb [5];
    logic [13:0] e;
    logic frame_prev, pend_f, commit_now, fexp;
    int n;
    n = cyc;
    if (!rst_ni) begin
      for (int r = 0; r < 5; r++) begin
        m_row[r] = '0; m_front[r] = '0; s_front[r] = '0;
      end
      m_en = 1'b0; s_en = 1'b0; m_pend = 1'b0; prev_ack = 1'b0;
      m_bright = 2'b11; s_bright = 2'b11;
    end else begin
      frame_prev = n > 0 && (n - 1) % FRAME == FRAME - 1;
      pend_f = m_pend;
      commit_now = 1'b0;
      rb = m_row;
      if (wb.wb_ack_o) begin
        n_tests++;
        if (prev_ack) begin
          n_fail++;
          $display("FAIL ack_width: ack high in two consecutive cycles at cyc %0d", n);
        end else if (q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: ack with no transaction at cyc %0d", n);
        end else begin
          t = q.pop_front();
          if (!t.we && wb.wb_dat_o !== t.exp) begin
            n_fail++;
            $display("FAIL read adr=%h: got %h exp %h", t.adr, wb.wb_dat_o, t.exp);
          end
          if (t.we && t.adr < 4'd5) m_row[t.adr] = t.dat[6:0];
          if (t.we && t.adr == 4'h8) begin
            m_en = t.dat[0];
            commit_now = t.dat[1];
          end
          if (t.we && t.adr == 4'h9) m_bright = t.dat[1:0];
        end
      end
      if (!DBUF) m_front = m_row;
      else if (frame_prev && (pend_f || commit_now)) begin
        m_front = rb;
        m_pend = 1'b0;
      end else if (commit_now) m_pend = 1'b1;
      e = n == 0 ? 14'h0 : exp_pins(n - 1);
      fexp = n % FRAME == FRAME - 1;
      n_tests++;
      if ({o, oe} !== e || frame !== fexp || (!wb.wb_ack_o && wb.wb_dat_o !== 8'h00)) begin
        n_fail++;
        $display("FAIL pins cyc=%0d: got o=%h oe=%h frame=%b dat=%h exp o=%h oe=%h frame=%b",
                 n, o, oe, frame, wb.wb_dat_o, e[13:7], e[6:0], fexp);
      end
      s_front = m_front; s_en = m_en; s_bright = m_bright;
      prev_ack = wb.wb_ack_o;
    end
  end

  initial begin
    logic [3:0] a;
    wb.wb_we_i = 1'b0; wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_stb_i = 1'b0;
    shadow_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({o, oe, frame, wb.wb_ack_o, wb.wb_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got o=%h oe=%h frame=%b ack=%b dat=%h, need all 0",
               o, oe, frame, wb.wb_ack_o, wb.wb_dat_o);
    end
    #2 rst_ni = 1'b1;
    xfer(0, 4'h9, 0); xfer(0, 4'h8, 0); xfer(0, 4'h0, 0); xfer(0, 4'hA, 0);
    xfer(1, 4'h0, 8'h01); xfer(1, 4'h8, 8'h01); run(60);
    xfer(1, 4'h4, 8'h40); xfer(1, 4'h9, 8'h01); run(60);
    xfer(1, 4'h9, 8'h01); xfer(0, 4'h9, 0); xfer(1, 4'hB, 8'h55); xfer(0, 4'hB, 0); xfer(0, 4'h0, 0);
    xfer(1, 4'h2, 8'h7F); xfer(1, 4'h9, 8'h03); run(40);
    xfer(1, 4'h9, 8'h00); run(30); xfer(0, 4'hA, 0);
    xfer(1, 4'h9, 8'h03); xfer(1, 4'h8, 8'h00); run(30); xfer(0, 4'hA, 0);
    xfer(1, 4'h8, 8'h01);
    if (DBUF) begin
      wait_phase(2);
      xfer(1, 4'h1, 8'h04); xfer(0, 4'h1, 0); xfer(1, 4'h8, 8'h03); xfer(0, 4'hA, 0);
      run(40); xfer(0, 4'hA, 0);
    end
    for (int i = 0; i < 80; i++) begin
      a = 4'($urandom_range(0, 15));
      xfer(1'($urandom_range(0, 1)), a, 8'($urandom));
      run($urandom_range(0, 6));
    end
    xfer(1, 4'h0, 8'h01); xfer(1, 4'h8, 8'h01); xfer(1, 4'h9, 8'h03);
    if (DBUF) begin
      xfer(1, 4'h8, 8'h03); run(60);
    end
    wait_phase(3);
    n_tests++;
    if (oe[1:0] !== 2'b11 || o[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_reset_lit: got o=%h oe=%h, need o[1:0]=2 oe[1:0]=3", o, oe);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({o, oe, frame, wb.wb_ack_o, wb.wb_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got o=%h oe=%h frame=%b ack=%b dat=%h, need all 0",
               o, oe, frame, wb.wb_ack_o, wb.wb_dat_o);
    end
    shadow_reset();
    repeat (2) @(negedge clk);
    #2 rst_ni = 1'b1;
    xfer(0, 4'h0, 0); xfer(0, 4'h9, 0); xfer(0, 4'h8, 0); xfer(0, 4'h3, 0);
    run(40);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, need 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
